// File: rtl/image_recv.sv
// Host-to-FPGA image loader: 8N1 UART receiver feeding a sync-byte framed
// parser that writes IMG_BYTES pixels into the model input buffer.
module image_recv #(
  parameter int          CLK_FREQ    = 50000000,
  parameter int          UART_BPS    = 115200,
  parameter int          IMG_BYTES   = 784,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int          TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       img_wr_en,
  output logic [9:0] img_wr_addr,
  output logic [7:0] img_wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t      rx_state, rx_nxt;
  logic           rxd_meta, rxd_sync, rxd_dly;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     rx_shift;
  logic           rx_valid, rx_ferr;
  logic           rx_valid_nxt, rx_ferr_nxt;
  logic           half_tick, bit_tick, restart, start_edge;

  assign half_tick  = (rx_cnt == CW'(HALF - 1));
  assign bit_tick   = (rx_cnt == CW'(BIT_CYC - 1));
  assign start_edge = rxd_dly & ~rxd_sync;
  assign restart    = ((rx_state == R_START) && half_tick) ||
                      (((rx_state == R_DATA) || (rx_state == R_STOP)) && bit_tick);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_dly  <= 1'b1;
      rx_state <= R_IDLE;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_dly  <= rxd_sync;
      rx_state <= rx_nxt;
    end
  end

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      R_IDLE:  if (start_edge) rx_nxt = R_START;
      R_START: if (half_tick) rx_nxt = rxd_sync ? R_IDLE : R_DATA;
      R_DATA:  if (bit_tick && bit_idx == 3'd7) rx_nxt = R_STOP;
      R_STOP:  if (bit_tick) rx_nxt = rxd_sync ? R_IDLE : R_WAIT;
      R_WAIT:  if (rxd_sync) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_nxt = (rx_state == R_STOP) && bit_tick && rxd_sync;
    rx_ferr_nxt  = (rx_state == R_STOP) && bit_tick && !rxd_sync;
  end

  // rx_shift stays stable after the stop sample, so it doubles as the byte out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_cnt   <= (rx_state == R_IDLE || restart) ? '0 : rx_cnt + 1'b1;
      rx_valid <= rx_valid_nxt;
      rx_ferr  <= rx_ferr_nxt;
      if (rx_state == R_START)
        bit_idx <= '0;
      else if (rx_state == R_DATA && bit_tick) begin
        bit_idx  <= bit_idx + 1'b1;
        rx_shift <= {rxd_sync, rx_shift[7:1]};
      end
    end
  end

  // ------------------------------------------------------------------ parser
  typedef enum logic {P_IDLE, P_PAYLOAD} p_state_t;

  p_state_t       p_state, p_nxt;
  logic [9:0]     pix_cnt;
  logic [TW-1:0]  timer;
  logic           last_pix, tmo;
  logic           wr_nxt, done_nxt, err_nxt;

  assign last_pix = (pix_cnt == 10'(IMG_BYTES - 1));
  assign tmo      = (timer == TW'(TIMEOUT_CYC - 1));
  assign busy     = (p_state == P_PAYLOAD);

  always_ff @(posedge clk) begin
    if (!rst_n) p_state <= P_IDLE;
    else        p_state <= p_nxt;
  end

  // a byte arriving in the expiry cycle takes priority over the timeout
  always_comb begin
    p_nxt = p_state;
    case (p_state)
      P_IDLE:
        if (rx_valid && rx_shift == SYNC_BYTE) p_nxt = P_PAYLOAD;
      P_PAYLOAD:
        if (rx_valid) begin
          if (last_pix) p_nxt = P_IDLE;
        end else if (rx_ferr || tmo) p_nxt = P_IDLE;
      default: p_nxt = P_IDLE;
    endcase
  end

  always_comb begin
    wr_nxt   = (p_state == P_PAYLOAD) && rx_valid;
    done_nxt = wr_nxt && last_pix;
    err_nxt  = (p_state == P_PAYLOAD) && !rx_valid && (rx_ferr || tmo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      timer       <= '0;
      img_wr_en   <= 1'b0;
      img_wr_addr <= '0;
      img_wr_data <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      img_wr_en  <= wr_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      timer      <= (p_state != P_PAYLOAD || rx_valid) ? '0 : timer + 1'b1;
      if (p_state == P_IDLE)
        pix_cnt <= '0;
      else if (rx_valid)
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      if (wr_nxt) begin
        img_wr_addr <= pix_cnt;
        img_wr_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_image_recv.sv
// Directed scoreboard bench for image_recv: expected writes are queued as bytes
// are driven and matched against writes captured from the buffer port.
module tb_image_recv;
  localparam int BIT = 16;
  localparam int IMG = 48;
  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       img_wr_en, frame_done, frame_err, busy;
  logic [9:0] img_wr_addr;
  logic [7:0] img_wr_data;

  always #5 clk = ~clk;

  image_recv #(
    .CLK_FREQ(1600000), .UART_BPS(100000), .IMG_BYTES(IMG),
    .SYNC_BYTE(8'hAA), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd),
    .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;

  wr_t    exp_q[$];
  wr_t    obs_q[$];
  int     errors = 0, checks = 0;
  int     done_cnt = 0, err_cnt = 0, both_cnt = 0;
  longint cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (img_wr_en) begin
      obs_q.push_back(wr_t'({img_wr_addr, img_wr_data, frame_done}));
      last_wr_cyc <= cyc;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
    if (frame_done && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (BIT) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // npix pixels of value (i mod 256), optionally with SYNC at one position
  task automatic send_pixels(input int npix, input int sync_at);
    logic [7:0] d;
    for (int i = 0; i < npix; i++) begin
      d = (i == sync_at) ? 8'hAA : 8'(i);
      exp_q.push_back(wr_t'({10'(i), d, (i == IMG - 1)}));
      send_byte(d);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    wr_t o, e;
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_wr%0d", tag, i), 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {img_wr_en, img_wr_addr, img_wr_data, frame_done, frame_err, busy}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    chk_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // normal frame
    send_byte(8'hAA);
    send_pixels(IMG, -1);
    drain("normal");
    chk("normal_done", done_cnt, 1);
    chk("normal_err", err_cnt, 0);
    chk("normal_busy", busy, 0);

    // leading garbage produces nothing until the sync byte
    send_byte(8'h00);
    send_byte(8'h55);
    drain("garbage");
    chk("garbage_busy", busy, 0);
    send_byte(8'hAA);
    send_pixels(IMG, -1);
    drain("after_garbage");
    chk("garbage_done", done_cnt, 2);

    // SYNC value as payload
    send_byte(8'hAA);
    send_pixels(IMG, 5);
    drain("sync_in_payload");
    chk("sync_done", done_cnt, 3);
    chk("sync_err", err_cnt, 0);

    // payload timeout
    send_byte(8'hAA);
    send_pixels(10, -1);
    drain("timeout_part");
    chk("timeout_busy_before", busy, 1);
    repeat (TMO + 100) @(negedge clk);
    chk("timeout_err", err_cnt, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_delay", 32'(last_err_cyc - last_wr_cyc), TMO);
    send_byte(8'hAA);
    send_pixels(IMG, -1);
    drain("after_timeout");
    chk("after_timeout_done", done_cnt, 4);

    // framing error mid-payload
    send_byte(8'hAA);
    send_pixels(3, -1);
    send_byte(8'h3C, 1'b0);
    drain("ferr");
    chk("ferr_err", err_cnt, 2);
    chk("ferr_busy", busy, 0);

    // short low glitch while idle is a false start
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    drain("glitch");
    chk("glitch_err", err_cnt, 2);
    chk("glitch_busy", busy, 0);

    // reset mid-frame
    send_byte(8'hAA);
    send_pixels(30, -1);
    drain("pre_reset");
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midframe_reset");
    rst_n = 1'b1;
    send_byte(8'h11);
    drain("post_reset_nosync");
    chk("post_reset_busy", busy, 0);
    send_byte(8'hAA);
    send_pixels(IMG, -1);
    drain("after_reset");
    chk("after_reset_done", done_cnt, 5);
    chk("final_err", err_cnt, 2);
    chk("done_err_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_recv.md
# image_recv

Receives one MNIST input image over UART and writes its pixels into the model's input buffer. It is the host-to-FPGA counterpart of the result transmit path. It contains its own 8N1 receiver and a frame parser. A frame is one sync byte followed by IMG_BYTES pixel bytes. On a complete frame it pulses `frame_done` to start inference.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate
- IMG_BYTES, 784, number of pixel bytes per frame
- SYNC_BYTE, 8'hAA, frame start marker
- TIMEOUT_CYC, 500000, maximum idle gap between payload bytes, in clk cycles

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- uart_rxd  in  1  asynchronous serial input, idle high
- img_wr_en  out  1  one-cycle write strobe to the image buffer
- img_wr_addr  out  10  pixel address, 0..IMG_BYTES-1
- img_wr_data  out  8  pixel value
- frame_done  out  1  one-cycle pulse when a full frame has been written
- frame_err  out  1  one-cycle pulse when a frame is aborted
- busy  out  1  high while the parser is in PAYLOAD

Reset and clock: rst_n, synchronous, active-low; clock clk.

## Operation
- Reset values: all outputs 0. Parser is in IDLE. Receiver is idle. Byte counter is 0.
- BIT_CYC = CLK_FREQ/UART_BPS, integer division; 434 with the defaults. HALF = BIT_CYC/2.

Receiver:
- uart_rxd passes through a 2-flop synchronizer, then one extra delay flop for edge detection.
- Start is detected on the synchronized 1→0 edge when the receiver is idle.
- The start bit is re-sampled at HALF. If it reads 1, this is a false start: return to idle and produce no byte.
- Data bits are sampled LSB first, each BIT_CYC after the previous sample.
- The stop bit is sampled at the same spacing. If it reads 1, rx_valid pulses for one cycle with the byte.
- If the stop bit reads 0, this is a framing error: no rx_valid, rx_ferr pulses instead. The receiver then waits for the line to be high before it re-arms.

Parser FSM (states IDLE, PAYLOAD):
- IDLE:
  - rx_valid with byte == SYNC_BYTE: go to PAYLOAD, counter = 0, timer = 0.
  - Any other byte is discarded.
  - rx_ferr is ignored, with no frame_err.
- PAYLOAD, on rx_valid:
  - Drive img_wr_en=1, img_wr_addr=counter, img_wr_data=byte. Counter increments and the timer clears.
  - SYNC_BYTE values are treated as ordinary pixel data; there is no re-sync.
  - When the written address is IMG_BYTES-1: frame_done=1 in the same cycle as that write, then go to IDLE with counter = 0.
- PAYLOAD, on rx_ferr: frame_err=1, go to IDLE. Pixels already written are left in the buffer.
- PAYLOAD, timeout: the timer counts every cycle without rx_valid. When it reaches TIMEOUT_CYC-1, frame_err=1 and go to IDLE.
- Simultaneous rx_valid and timer expiry in the same cycle: rx_valid wins and the timer clears.
- busy = (state == PAYLOAD).
- Reset mid-frame: the receiver and parser return to their reset state immediately. A byte in flight is lost, and the next frame must start with SYNC_BYTE.

## Timing
- rx_valid is asserted 1 cycle after the stop-bit sample clock.
- img_wr_en is registered and asserted 1 cycle after rx_valid.
- End-to-end latency from the synchronized start edge to img_wr_en = HALF + 9*BIT_CYC + 2 cycles.
- There is no back-pressure. The buffer must accept one write per byte time; writes are at least BIT_CYC*10 cycles apart.
- frame_done and frame_err are never both high in the same cycle. Each is exactly 1 cycle wide.
- img_wr_addr and img_wr_data hold their last values when img_wr_en=0.
- Counter width is 10 bits. IMG_BYTES ≤ 1024 is required.

## Test plan
- Normal frame: send 0xAA, then 784 bytes with pixel value (i mod 256). Expect 784 writes at addresses 0..783 with data i mod 256, frame_done on the address-783 write, and frame_err never asserted.
- Leading garbage: send 0x00, 0x55, then 0xAA, then 784 bytes. Expect no writes before the 0xAA, and exactly 784 writes after it.
- Sync inside payload: a frame whose pixel 5 = 0xAA. Expect a write at address 5 with data 0xAA, the frame still completes at address 783, and one frame_done.
- Timeout: use TIMEOUT_CYC=5000. Send 0xAA and 10 pixels, then stop. Expect frame_err 5000 cycles after the last rx_valid and busy→0. A following full frame writes from address 0 again.
- Framing error and false start:
  - A byte with stop bit 0 during payload gives frame_err and a return to IDLE.
  - A 100-cycle low glitch on uart_rxd while idle gives no write and no error.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 300 pixels. Expect all outputs 0 and busy 0. A subsequent full frame writes addresses 0..783 and produces frame_done.
